// File: rtl/ee354_ssd_capture.sv
// Recovers the 4-digit hex value shown on a multiplexed, active-low seven-segment display
// by watching its anode and cathode lines, with glitch filtering, frame sequencing and timeout.
module ee354_ssd_capture #(
    parameter int STABLE_N = 16,
    parameter int TIMEOUT  = 2000000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [3:0]  An,
    input  logic [7:0]  Cath,
    input  logic        Clr,
    output logic [15:0] Hex,
    output logic [3:0]  Dp_Out,
    output logic        Frame_Pulse,
    output logic        Frame_Valid,
    output logic        Scan_Lost,
    output logic        Err_Seg,
    output logic        Err_Anode
);

    localparam int SW = $clog2(STABLE_N + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_N - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_WAIT, S_D3, S_D2, S_D1} state_t;

    state_t        state_q, state_d;
    logic [3:0]    an_q, an_d, prev_an_q, prev_an_d;
    logic [7:0]    cath_q, cath_d, prev_cath_q, prev_cath_d;
    logic [SW-1:0] stab_q, stab_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [11:0]   stage_hex_q, stage_hex_d;
    logic [2:0]    stage_dp_q, stage_dp_d;
    logic [15:0]   hex_q, hex_d;
    logic [3:0]    dp_q, dp_d;
    logic          pulse_q, pulse_d;
    logic          valid_q, valid_d;
    logic          err_seg_q, err_seg_d;
    logic          err_anode_q, err_anode_d;

    logic          single, multi, same, capture, lost, seg_ok, dp_bit;
    logic [3:0]    digit;

    always_comb begin
        single = 1'b0;
        multi  = 1'b0;
        case (an_q)
            4'b0111, 4'b1011, 4'b1101, 4'b1110: single = 1'b1;
            4'b1111:                            single = 1'b0;
            default:                            multi  = 1'b1;
        endcase
    end

    always_comb begin
        seg_ok = 1'b1;
        digit  = 4'h0;
        case (cath_q[7:1])
            7'b0000001: digit = 4'h0;
            7'b1001111: digit = 4'h1;
            7'b0010010: digit = 4'h2;
            7'b0000110: digit = 4'h3;
            7'b1001100: digit = 4'h4;
            7'b0100100: digit = 4'h5;
            7'b0100000: digit = 4'h6;
            7'b0001111: digit = 4'h7;
            7'b0000000: digit = 4'h8;
            7'b0000100: digit = 4'h9;
            7'b0001000: digit = 4'hA;
            7'b1100000: digit = 4'hB;
            7'b0110001: digit = 4'hC;
            7'b1000010: digit = 4'hD;
            7'b0110000: digit = 4'hE;
            7'b0111000: digit = 4'hF;
            default:    seg_ok = 1'b0;
        endcase
    end

    // Stability counter saturates at its last value so a long dwell captures only once.
    always_comb begin
        an_d        = An;
        cath_d      = Cath;
        prev_an_d   = an_q;
        prev_cath_d = cath_q;
        same        = (an_q == prev_an_q) && (cath_q == prev_cath_q);
        stab_d      = '0;
        capture     = 1'b0;
        if (single && same) begin
            stab_d  = (stab_q == STAB_LAST) ? stab_q : stab_q + SW'(1);
            capture = (stab_q == STAB_LAST - SW'(1));
        end
        lost   = (tmo_q == TMO_MAX);
        dp_bit = ~cath_q[0];
        if (capture) begin
            tmo_d = '0;
        end else if (lost) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        stage_hex_d = stage_hex_q;
        stage_dp_d  = stage_dp_q;
        hex_d       = hex_q;
        dp_d        = dp_q;
        pulse_d     = 1'b0;
        valid_d     = lost ? 1'b0 : valid_q;
        if (capture) begin
            if (!seg_ok) begin
                state_d = S_WAIT;
            end else if (an_q == 4'b0111) begin
                state_d           = S_D3;
                stage_hex_d[11:8] = digit;
                stage_dp_d[2]     = dp_bit;
            end else begin
                case (state_q)
                    S_WAIT: state_d = S_WAIT;
                    S_D3: begin
                        state_d = S_WAIT;
                        if (an_q == 4'b1011) begin
                            state_d          = S_D2;
                            stage_hex_d[7:4] = digit;
                            stage_dp_d[1]    = dp_bit;
                        end
                    end
                    S_D2: begin
                        state_d = S_WAIT;
                        if (an_q == 4'b1101) begin
                            state_d          = S_D1;
                            stage_hex_d[3:0] = digit;
                            stage_dp_d[0]    = dp_bit;
                        end
                    end
                    S_D1: begin
                        state_d = S_WAIT;
                        if (an_q == 4'b1110) begin
                            hex_d   = {stage_hex_q, digit};
                            dp_d    = {stage_dp_q, dp_bit};
                            pulse_d = 1'b1;
                            valid_d = 1'b1;
                        end
                    end
                    default: state_d = S_WAIT;
                endcase
            end
        end else if (lost) begin
            state_d = S_WAIT;
        end
        err_seg_d   = (capture && !seg_ok) || (err_seg_q && !Clr);
        err_anode_d = multi || (err_anode_q && !Clr);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_WAIT;
            an_q        <= 4'b1111;
            cath_q      <= 8'hFF;
            prev_an_q   <= 4'b1111;
            prev_cath_q <= 8'hFF;
            stab_q      <= '0;
            tmo_q       <= '0;
            stage_hex_q <= '0;
            stage_dp_q  <= '0;
            hex_q       <= '0;
            dp_q        <= '0;
            pulse_q     <= 1'b0;
            valid_q     <= 1'b0;
            err_seg_q   <= 1'b0;
            err_anode_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            an_q        <= an_d;
            cath_q      <= cath_d;
            prev_an_q   <= prev_an_d;
            prev_cath_q <= prev_cath_d;
            stab_q      <= stab_d;
            tmo_q       <= tmo_d;
            stage_hex_q <= stage_hex_d;
            stage_dp_q  <= stage_dp_d;
            hex_q       <= hex_d;
            dp_q        <= dp_d;
            pulse_q     <= pulse_d;
            valid_q     <= valid_d;
            err_seg_q   <= err_seg_d;
            err_anode_q <= err_anode_d;
        end
    end

    assign Hex         = hex_q;
    assign Dp_Out      = dp_q;
    assign Frame_Pulse = pulse_q;
    assign Frame_Valid = valid_q && !lost;
    assign Scan_Lost   = lost;
    assign Err_Seg     = err_seg_q;
    assign Err_Anode   = err_anode_q;

endmodule

// File: tb/tb_ee354_ssd_capture.sv
// Testbench for ee354_ssd_capture: directed display scans checked every cycle against
// a digit-sequence model of the capture rules, plus literal checks at key points.
module tb_ee354_ssd_capture;

    localparam int STABLE_N = 4;
    localparam int TIMEOUT  = 64;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  An = 4'hF;
    logic [7:0]  Cath = 8'hFF;
    logic        Clr = 1'b0;
    logic [15:0] Hex;
    logic [3:0]  Dp_Out;
    logic        Frame_Pulse, Frame_Valid, Scan_Lost, Err_Seg, Err_Anode;

    int n_checks = 0;
    int n_fails  = 0;
    int pulse_count = 0;
    bit checking = 1'b0;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    ee354_ssd_capture #(.STABLE_N(STABLE_N), .TIMEOUT(TIMEOUT)) dut (
        .Clk(Clk), .Reset(Reset), .An(An), .Cath(Cath), .Clr(Clr),
        .Hex(Hex), .Dp_Out(Dp_Out), .Frame_Pulse(Frame_Pulse), .Frame_Valid(Frame_Valid),
        .Scan_Lost(Scan_Lost), .Err_Seg(Err_Seg), .Err_Anode(Err_Anode)
    );

    always #5 Clk = ~Clk;

    // Model state: the sample the design sees, how long it has been held, and the frame progress.
    logic [3:0]  m_an = 4'hF;
    logic [7:0]  m_cath = 8'hFF;
    int          m_run = 0, m_pos = 0, m_idle = 0;
    logic [15:0] m_hex = '0, m_stage_hex = '0;
    logic [3:0]  m_dp = '0, m_stage_dp = '0;
    bit          m_pulse = 0, m_valid = 0, m_eseg = 0, m_eanode = 0;

    function automatic int anode_index(input logic [3:0] an);
        if (an == 4'hF) return -1;
        if ($countones(~an) != 1) return -2;
        for (int i = 0; i < 4; i++) if (!an[i]) return i;
        return -2;
    endfunction

    function automatic int glyph_value(input logic [6:0] seg);
        for (int i = 0; i < 16; i++) if (glyph[i] == seg) return i;
        return -1;
    endfunction

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            m_an = 4'hF; m_cath = 8'hFF; m_run = 0; m_pos = 0; m_idle = 0;
            m_hex = '0; m_stage_hex = '0; m_dp = '0; m_stage_dp = '0;
            m_pulse = 0; m_valid = 0; m_eseg = 0; m_eanode = 0;
        end else begin
            int  k, d, kn;
            bit  cap, lost, seg_err;
            k = anode_index(m_an);
            cap = (k >= 0) && (m_run == STABLE_N);
            lost = (m_idle == TIMEOUT);
            seg_err = 0;
            m_pulse = 0;
            if (lost) m_valid = 0;
            if (k == -2) m_eanode = 1; else if (Clr) m_eanode = 0;
            if (cap) begin
                d = glyph_value(m_cath[7:1]);
                if (d < 0) begin
                    seg_err = 1;
                    m_pos = 0;
                end else if (k == 3) begin
                    m_pos = 1;
                    m_stage_hex[15:12] = d[3:0];
                    m_stage_dp[3] = ~m_cath[0];
                end else if (m_pos != 0 && k == 3 - m_pos) begin
                    m_stage_hex[k*4 +: 4] = d[3:0];
                    m_stage_dp[k] = ~m_cath[0];
                    m_pos++;
                    if (m_pos == 4) begin
                        m_hex = m_stage_hex; m_dp = m_stage_dp;
                        m_pulse = 1; m_valid = 1; m_pos = 0;
                    end
                end else begin
                    m_pos = 0;
                end
                m_idle = 0;
            end else begin
                if (lost) m_pos = 0;
                if (m_idle < TIMEOUT) m_idle++;
            end
            if (seg_err) m_eseg = 1; else if (Clr) m_eseg = 0;
            kn = anode_index(An);
            if (kn >= 0 && An == m_an && Cath == m_cath) m_run++;
            else m_run = (kn >= 0) ? 1 : 0;
            m_an = An; m_cath = Cath;
        end
    end

    task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge Clk) begin
        if (Frame_Pulse === 1'b1) pulse_count++;
        if (checking) begin
            check_output("model_hex", Hex, m_hex);
            check_output("model_dp", {12'd0, Dp_Out}, {12'd0, m_dp});
            check_output("model_pulse", {15'd0, Frame_Pulse}, {15'd0, m_pulse});
            check_output("model_valid", {15'd0, Frame_Valid}, {15'd0, m_valid && (m_idle != TIMEOUT)});
            check_output("model_lost", {15'd0, Scan_Lost}, {15'd0, m_idle == TIMEOUT});
            check_output("model_err_seg", {15'd0, Err_Seg}, {15'd0, m_eseg});
            check_output("model_err_anode", {15'd0, Err_Anode}, {15'd0, m_eanode});
        end
    end

    task automatic apply_stimulus(input logic [3:0] an, input logic [7:0] cath, input int cycles);
        An = an;
        Cath = cath;
        repeat (cycles) @(posedge Clk);
        #1;
    endtask

    task automatic show_digit(input int idx, input int val, input bit dp, input int cycles);
        logic [3:0] an;
        an = 4'hF;
        an[idx] = 1'b0;
        apply_stimulus(an, {glyph[val], ~dp}, cycles);
    endtask

    task automatic scan(input logic [15:0] value, input logic [3:0] dps, input int dwell);
        for (int i = 3; i >= 0; i--) show_digit(i, int'(value[i*4 +: 4]), dps[i], dwell);
    endtask

    initial begin
        int base;
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        repeat (3) @(posedge Clk);
        #1;
        checking = 1'b1;
        check_output("reset_hex", Hex, 16'h0000);
        check_output("reset_valid", {15'd0, Frame_Valid}, 16'd0);
        Reset = 1'b1;
        apply_stimulus(4'hF, 8'hFF, 2);

        base = pulse_count;
        scan(16'h1234, 4'b0000, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("scan1234_pulses", 16'(pulse_count - base), 16'd1);
        check_output("scan1234_hex", Hex, 16'h1234);
        check_output("scan1234_dp", {12'd0, Dp_Out}, 16'd0);
        check_output("scan1234_valid", {15'd0, Frame_Valid}, 16'd1);

        base = pulse_count;
        scan(16'h5678, 4'b0000, 3);
        scan(16'h9ABC, 4'b0000, 3);
        for (int i = 0; i < 100 && !Scan_Lost; i++) apply_stimulus(4'hF, 8'hFF, 1);
        check_output("short_dwell_pulses", 16'(pulse_count - base), 16'd0);
        check_output("timeout_lost", {15'd0, Scan_Lost}, 16'd1);
        check_output("timeout_valid", {15'd0, Frame_Valid}, 16'd0);
        check_output("timeout_hex_kept", Hex, 16'h1234);

        base = pulse_count;
        show_digit(3, 5, 0, 8);
        show_digit(1, 6, 0, 8);
        show_digit(2, 7, 0, 8);
        show_digit(0, 8, 0, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("bad_order_pulses", 16'(pulse_count - base), 16'd0);
        check_output("bad_order_lost_cleared", {15'd0, Scan_Lost}, 16'd0);
        check_output("bad_order_valid", {15'd0, Frame_Valid}, 16'd0);
        scan(16'hABCD, 4'b0000, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("scanABCD_hex", Hex, 16'hABCD);
        check_output("scanABCD_valid", {15'd0, Frame_Valid}, 16'd1);

        base = pulse_count;
        apply_stimulus(4'b0011, {glyph[1], 1'b1}, 5);
        apply_stimulus(4'hF, 8'hFF, 3);
        check_output("multi_err_anode", {15'd0, Err_Anode}, 16'd1);
        check_output("multi_no_capture", 16'(pulse_count - base), 16'd0);
        Clr = 1'b1;
        apply_stimulus(4'hF, 8'hFF, 1);
        Clr = 1'b0;
        apply_stimulus(4'hF, 8'hFF, 1);
        check_output("clr_err_anode", {15'd0, Err_Anode}, 16'd0);
        Clr = 1'b1;
        apply_stimulus(4'b0101, 8'hFF, 2);
        Clr = 1'b0;
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("clr_vs_event", {15'd0, Err_Anode}, 16'd1);

        base = pulse_count;
        show_digit(3, 9, 0, 8);
        apply_stimulus(4'b1011, 8'hFF, 8);
        show_digit(1, 1, 0, 8);
        show_digit(0, 2, 0, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("bad_seg_err", {15'd0, Err_Seg}, 16'd1);
        check_output("bad_seg_hex_kept", Hex, 16'hABCD);
        check_output("bad_seg_no_commit", 16'(pulse_count - base), 16'd0);

        show_digit(3, 15, 1, 8);
        show_digit(2, 0, 1, 8);
        show_digit(1, 0, 1, 8);
        Reset = 1'b0;
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("midframe_reset_hex", Hex, 16'h0000);
        check_output("midframe_reset_errs", {14'd0, Err_Seg, Err_Anode}, 16'd0);
        Reset = 1'b1;
        base = pulse_count;
        show_digit(0, 15, 1, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("partial_discarded", 16'(pulse_count - base), 16'd0);
        scan(16'hF00F, 4'b1111, 8);
        apply_stimulus(4'hF, 8'hFF, 2);
        check_output("scanF00F_hex", Hex, 16'hF00F);
        check_output("scanF00F_dp", {12'd0, Dp_Out}, 16'h000F);
        check_output("scanF00F_pulses", 16'(pulse_count - base), 16'd1);

        checking = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
